regfile_sb: RTL

Parametrised multi-read-port integer register file for the RV32I core with same-cycle write bypass, a per-register pending-write scoreboard and a sequential clear engine. It sits between decode, which reads operands and issues destinations, and writeback, which retires results. x0 stays hardwired to zero. The scoreboard gives the hazard unit per-operand busy status without external bookkeeping.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 40 ++++
 rtl/regfile_sb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and clear-engine state encoding for the integer register file.
// Pure declarations: no logic, no latency, no flow control.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic {
    CLR_IDLE,
    CLR_ACTIVE
  } clr_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write bits, one per register; bit 0 is never set.
// Updates on the clock edge (visible next cycle); no backpressure, inputs arrive pre-qualified.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int   NREG = NREG_DEF,
  localparam int  AW   = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            clr_all,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_q;

  // Precedence: bulk clear, then issue, then writeback retire.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      busy_q <= '0;
    end else if (clr_all) begin
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (iss_en && (iss_addr == AW'(r))) begin
          busy_q[r] <= 1'b1;
        end else if (wb_en && (wb_addr == AW'(r))) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port RV32I register file with same-cycle write bypass, pending-write scoreboard and clear engine.
// Reads combinational, writes land next edge; no backpressure, clear ignores writeback/issue for NREG-1 cycles.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  XLEN   = XLEN_DEF,
  parameter int  NREG   = NREG_DEF,
  parameter int  NRP    = 2,
  parameter bit  BYPASS = 1'b1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NRP*AW-1:0] i_rs_addr,
  output logic [NRP*XLEN-1:0] o_rs_data,
  output logic [NRP-1:0]    o_rs_busy,
  input  logic [AW-1:0]     i_rd_addr,
  input  logic              i_rd_wren,
  input  logic [XLEN-1:0]   i_rd_data,
  input  logic [AW-1:0]     i_iss_addr,
  input  logic              i_iss_valid,
  input  logic              i_flush,
  input  logic              i_clear,
  output logic              o_clear_busy
);

  clr_state_e      state_q;
  logic [AW-1:0]   cnt_q;
  logic            clr_busy_q;
  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] sb_busy;

  logic idle;
  logic wb_en;
  logic iss_en;
  logic clr_start;

  assign idle      = (state_q == CLR_IDLE);
  assign wb_en     = idle && i_rd_wren && (i_rd_addr != '0);
  assign iss_en    = idle && i_iss_valid && (i_iss_addr != '0);
  assign clr_start = idle && i_clear;

  // cnt_q starts at 1 so entry 0 is never touched; it is only ever reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= CLR_IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          if (i_clear) begin
            state_q    <= CLR_ACTIVE;
            cnt_q      <= AW'(1);
            clr_busy_q <= 1'b1;
          end
        end
        CLR_ACTIVE: begin
          if (cnt_q == AW'(NREG - 1)) begin
            state_q    <= CLR_IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: begin
          state_q    <= CLR_IDLE;
          cnt_q      <= '0;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_clear_busy = clr_busy_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int r = 0; r < NREG; r++) begin
        mem_q[r] <= '0;
      end
    end else if (!idle) begin
      mem_q[cnt_q] <= '0;
    end else if (wb_en) begin
      mem_q[i_rd_addr] <= i_rd_data;
    end
  end

  regfile_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .clr_all  (i_flush || clr_start),
    .iss_en   (iss_en),
    .iss_addr (i_iss_addr),
    .wb_en    (wb_en),
    .wb_addr  (i_rd_addr),
    .busy     (sb_busy)
  );

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            rd_ok;
    logic            hit;
    logic            iss_hit;
    logic [XLEN-1:0] rd_dat;
    logic            rd_busy;

    assign ra      = i_rs_addr[k*AW +: AW];
    assign rd_ok   = idle && (ra != '0);
    assign hit     = BYPASS && wb_en && (i_rd_addr == ra);
    assign iss_hit = iss_en && (i_iss_addr == ra);

    // A retiring write clears the busy view unless the same register is re-issued this cycle.
    assign rd_dat  = rd_ok ? (hit ? i_rd_data : mem_q[ra]) : '0;
    assign rd_busy = rd_ok && sb_busy[ra] && !(hit && !iss_hit);

    assign o_rs_data[k*XLEN +: XLEN] = rd_dat;
    assign o_rs_busy[k]              = rd_busy;
  end

endmodule
